// File: rtl/button_press_classifier_if.sv
// Pin-side and classified-output signals of the push-button classifier.
// master drives the raw pin and reads the codes; slave is the classifier itself.
interface button_press_classifier_if;
   logic       button;
   logic [1:0] buttonState;
   logic       pressed;

   modport master (
      output button,
      input  buttonState,
      input  pressed
   );

   modport slave (
      input  button,
      output buttonState,
      output pressed
   );
endinterface

// File: rtl/button_press_classifier.sv
// Push-button synchronizer, debouncer and short/long press classifier emitting one-cycle press codes.
// Optional build macro BUTTON_AUTO_REPEAT_EN: periodic code 1 pulses while a long press is held.
module button_press_classifier #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 150_000_000,
   parameter int REPEAT_CYCLES   = 10_000_000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic reset,
   button_press_classifier_if.slave bus
);
   localparam int SYNC_STAGES = 2;
   localparam int MAX_DL      = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
   localparam int MAX_CYCLES  = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
   localparam int CW          = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CW-1:0] CNT_SAT   = '1;
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif
   localparam logic IDLE_LEVEL = BTN_ACTIVE_LOW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DB_PRESS,
      S_PRESSED,
      S_HELD,
      S_DB_REL
   } state_t;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_next;
   logic [SYNC_STAGES-1:0] valid_reg;
   logic [SYNC_STAGES-1:0] valid_next;

   // valid tracks which stages hold a real pin sample rather than the reset fill
   for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_head
         assign sync_next[gi]  = bus.button;
         assign valid_next[gi] = 1'b1;
      end else begin : g_tail
         assign sync_next[gi]  = sync_reg[gi-1];
         assign valid_next[gi] = valid_reg[gi-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_reg  <= {SYNC_STAGES{IDLE_LEVEL}};
         valid_reg <= '0;
      end else begin
         sync_reg  <= sync_next;
         valid_reg <= valid_next;
      end
   end

   logic p;
   logic p_valid;
   assign p       = BTN_ACTIVE_LOW ? ~sync_reg[SYNC_STAGES-1] : sync_reg[SYNC_STAGES-1];
   assign p_valid = valid_reg[SYNC_STAGES-1];

   state_t        state_reg;
   state_t        state_next;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic [CW-1:0] cnt_inc;
   logic          long_done_reg;
   logic          long_done_next;
   logic          armed_reg;
   logic          armed_next;
   logic          pressed_reg;
   logic          pressed_next;
   logic [1:0]    code_reg;
   logic [1:0]    code_next;

   assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CW'(1);

   // armed blocks a button still held across reset: a genuine released sample must be seen first
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      long_done_next = long_done_reg;
      armed_next     = armed_reg;
      pressed_next   = pressed_reg;
      code_next      = 2'd0;

      case (state_reg)
         S_IDLE: begin
            cnt_next = '0;
            if (p_valid && !p) begin
               armed_next = 1'b1;
            end
            if (armed_reg && p) begin
               state_next = S_DB_PRESS;
            end
         end

         S_DB_PRESS: begin
            if (!p) begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == DB_LAST) begin
               state_next   = S_PRESSED;
               cnt_next     = '0;
               pressed_next = 1'b1;
            end else begin
               cnt_next = cnt_inc;
            end
         end

         S_PRESSED: begin
            if (!p) begin
               state_next     = S_DB_REL;
               long_done_next = 1'b0;
               cnt_next       = '0;
            end else if (cnt_reg == LONG_LAST) begin
               state_next = S_HELD;
               code_next  = 2'd2;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_inc;
            end
         end

         S_HELD: begin
            if (!p) begin
               state_next     = S_DB_REL;
               long_done_next = 1'b1;
               cnt_next       = '0;
            end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
               if (cnt_reg == REP_LAST) begin
                  code_next = 2'd1;
                  cnt_next  = '0;
               end else begin
                  cnt_next = cnt_inc;
               end
`else
               cnt_next = '0;
`endif
            end
         end

         S_DB_REL: begin
            // a bounce restarts the release window but never returns to hold timing
            if (p) begin
               cnt_next = '0;
            end else if (cnt_reg == DB_LAST) begin
               state_next   = S_IDLE;
               cnt_next     = '0;
               pressed_next = 1'b0;
               if (!long_done_reg) begin
                  code_next = 2'd1;
               end
            end else begin
               cnt_next = cnt_inc;
            end
         end

         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         long_done_reg <= 1'b0;
         armed_reg     <= 1'b0;
         pressed_reg   <= 1'b0;
         code_reg      <= 2'd0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         long_done_reg <= long_done_next;
         armed_reg     <= armed_next;
         pressed_reg   <= pressed_next;
         code_reg      <= code_next;
      end
   end

   assign bus.buttonState = code_reg;
   assign bus.pressed     = pressed_reg;

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier: press-pattern table, hand-written reset sequence
// and randomized presses, all compared cycle by cycle against a pin-history reference model.
module tb_button_press_classifier;
   localparam int DB = 4;
   localparam int LG = 20;
   localparam int RP = 5;

   logic clk;
   logic reset;
   button_press_classifier_if bus();

   button_press_classifier #(
      .DEBOUNCE_CYCLES(DB),
      .LONG_CYCLES    (LG),
      .REPEAT_CYCLES  (RP),
      .BTN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // reference model state: pin delay line plus press/release bookkeeping in sample counts
   bit         m_s1, m_s2, m_v1, m_v2;
   bit         m_armed, m_pressed, m_rel, m_bounced, m_long;
   int         m_ones, m_zrun, m_hold;
   logic [1:0] m_code;

   // observation bookkeeping
   int cyc;
   int n_short, n_long;
   int rise_cyc, long_cyc, short_cyc;
   bit prev_pressed;

   typedef struct {
      int low_len;
      bit bounce;
      int exp_short;
      int exp_long;
      int exp_rep;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_s1 = 1'b1; m_s2 = 1'b1; m_v1 = 1'b0; m_v2 = 1'b0;
      m_armed = 0; m_pressed = 0; m_rel = 0; m_bounced = 0; m_long = 0;
      m_ones = 0; m_zrun = 0; m_hold = 0;
      m_code = 2'd0;
   endtask

   task automatic model_edge(input logic pin);
      bit ps, pv;
      if (!reset) begin
         model_reset();
         return;
      end
      ps = ~m_s2;
      pv = m_v2;
      m_s2 = m_s1; m_v2 = m_v1;
      m_s1 = pin;  m_v1 = 1'b1;
      m_code = 2'd0;
      if (ps) m_ones++; else m_ones = 0;

      if (!m_pressed) begin
         if (m_armed && m_ones == DB + 1) begin
            m_pressed = 1; m_hold = 0; m_long = 0; m_rel = 0;
         end
      end else if (!m_rel) begin
         if (ps) begin
            m_hold++;
            if (m_hold == LG) m_code = 2'd2;
`ifdef BUTTON_AUTO_REPEAT_EN
            else if (m_hold > LG && ((m_hold - LG) % RP) == 0) m_code = 2'd1;
`endif
         end else begin
            m_rel = 1; m_bounced = 0; m_zrun = 1;
            m_long = (m_hold >= LG);
         end
      end else begin
         if (ps) begin
            m_bounced = 1; m_zrun = 0;
         end else begin
            m_zrun++;
            if (m_zrun == (m_bounced ? DB : DB + 1)) begin
               m_pressed = 0; m_rel = 0;
               if (!m_long) m_code = 2'd1;
            end
         end
      end
      if (pv && !ps) m_armed = 1;
   endtask

   task automatic step(input logic pin);
      bus.button = pin;
      @(posedge clk);
      model_edge(pin);
      cyc++;
      #1;
      check("buttonState", int'(bus.buttonState), int'(m_code));
      check("pressed", int'(bus.pressed), int'(m_pressed));
      if (bus.buttonState == 2'd1) begin
         n_short++;
         if (short_cyc < 0) short_cyc = cyc;
      end
      if (bus.buttonState == 2'd2) begin
         n_long++;
         if (long_cyc < 0) long_cyc = cyc;
      end
      if (bus.pressed && !prev_pressed && rise_cyc < 0) rise_cyc = cyc;
      prev_pressed = bus.pressed;
   endtask

   task automatic clear_obs();
      n_short = 0; n_long = 0;
      rise_cyc = -1; long_cyc = -1; short_cyc = -1;
   endtask

   initial begin
      int rel_cyc;
      int rep_exp;

`ifdef BUTTON_AUTO_REPEAT_EN
      rep_exp = 1;
`else
      rep_exp = 0;
`endif
      //            low  bnc  short long repeats
      vecs[0] = '{3,  1'b0, 0, 0, 0};
      vecs[1] = '{4,  1'b0, 0, 0, 0};
      vecs[2] = '{5,  1'b0, 1, 0, 0};
      vecs[3] = '{10, 1'b1, 1, 0, 0};
      vecs[4] = '{24, 1'b0, 1, 0, 0};
      vecs[5] = '{25, 1'b0, 0, 1, 0};
      vecs[6] = '{40, 1'b0, 0, 1, 3 * rep_exp};
      vecs[7] = '{30, 1'b1, 0, 1, 1 * rep_exp};

      cyc = 0;
      prev_pressed = 1'b0;
      clear_obs();
      model_reset();
      reset = 1'b0;
      bus.button = 1'b1;
      repeat (3) step(1'b1);
      #2 reset = 1'b1;
      repeat (6) step(1'b1);

      for (int i = 0; i < 8; i++) begin
         clear_obs();
         for (int k = 0; k < vecs[i].low_len; k++) step(1'b0);
         rel_cyc = cyc + 1;
         if (vecs[i].bounce) begin
            step(1'b1); step(1'b0); step(1'b1); step(1'b0);
         end
         for (int k = 0; k < 30; k++) step(1'b1);
         $display("vec %0d low=%0d bounce=%0d code1=%0d code2=%0d", i, vecs[i].low_len,
                  vecs[i].bounce, n_short, n_long);
         check("vec_code1_count", n_short, vecs[i].exp_short + vecs[i].exp_rep);
         check("vec_code2_count", n_long, vecs[i].exp_long);
         if (vecs[i].exp_long != 0)
            check("long_delay_after_pressed", long_cyc - rise_cyc, LG);
         if (vecs[i].exp_short != 0 && !vecs[i].bounce)
            check("short_delay_after_release", short_cyc - rel_cyc, 2 + DB);
      end

      // asynchronous reset in the middle of a hold, then release/re-press required
      clear_obs();
      for (int k = 0; k < 15; k++) step(1'b0);
      check("pressed_before_reset", int'(bus.pressed), 1);
      #2 reset = 1'b0;
      #1;
      check("async_reset_code", int'(bus.buttonState), 0);
      check("async_reset_pressed", int'(bus.pressed), 0);
      model_reset();
      repeat (3) step(1'b0);
      #2 reset = 1'b1;
      clear_obs();
      for (int k = 0; k < 40; k++) step(1'b0);
      $display("reset-held window code1=%0d code2=%0d", n_short, n_long);
      check("held_through_reset_codes", n_short + n_long, 0);
      check("held_through_reset_pressed", rise_cyc, -1);
      clear_obs();
      repeat (10) step(1'b1);
      repeat (8) step(1'b0);
      repeat (15) step(1'b1);
      $display("re-press after reset code1=%0d code2=%0d", n_short, n_long);
      check("repress_after_reset_code1", n_short, 1);

      // randomized presses with optional bouncy releases
      for (int t = 0; t < 30; t++) begin
         int low_len, bnc, high_len;
         clear_obs();
         low_len  = $urandom_range(1, 45);
         bnc      = $urandom_range(0, 6);
         high_len = $urandom_range(2, 14);
         for (int k = 0; k < low_len; k++) step(1'b0);
         for (int k = 0; k < bnc; k++) step(logic'($urandom_range(0, 1)));
         for (int k = 0; k < high_len; k++) step(1'b1);
         $display("rand %0d low=%0d bounce=%0d high=%0d code1=%0d code2=%0d", t, low_len, bnc,
                  high_len, n_short, n_long);
      end
      repeat (20) step(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
